// File: rtl/fminmax_pipe.sv
// Two-stage IEEE-754 minimum/maximum unit with NaN handling and a global-stall valid/ready pipe.
// Stage 1 classifies and compares the operands; stage 2 selects the result and registers the flag.
module fminmax_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] read_data1,
  input  logic [W-1:0] read_data2,
  input  logic         op_max,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result_out,
  output logic         nv_flag
);

  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic             w_a_sign, w_b_sign;
  logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic             w_mag_lt, w_mag_eq, w_a_lt_b, w_eq;
  logic             w_advance;
  logic [W-1:0]     w_canon_nan;
  logic [W-1:0]     w_sel;

  logic             r_s1_valid;
  logic [W-1:0]     r_s1_a, r_s1_b;
  logic             r_s1_op_max;
  logic             r_s1_a_nan, r_s1_b_nan;
  logic             r_s1_nv;
  logic             r_s1_a_lt_b;
  logic             r_s1_eq;

  logic             r_out_valid;
  logic [W-1:0]     r_result;
  logic             r_nv;

  assign w_a_sign = read_data1[W-1];
  assign w_b_sign = read_data2[W-1];
  assign w_a_exp  = read_data1[W-2 -: EXP_W];
  assign w_b_exp  = read_data2[W-2 -: EXP_W];
  assign w_a_man  = read_data1[MAN_W-1:0];
  assign w_b_man  = read_data2[MAN_W-1:0];

  assign w_a_nan  = (&w_a_exp) && (|w_a_man);
  assign w_b_nan  = (&w_b_exp) && (|w_b_man);
  assign w_a_snan = w_a_nan && !w_a_man[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_b_man[MAN_W-1];

  // Total order on sign-magnitude: negatives reverse the magnitude order, -0 < +0 via sign.
  assign w_mag_lt = read_data1[W-2:0] < read_data2[W-2:0];
  assign w_mag_eq = read_data1[W-2:0] == read_data2[W-2:0];
  assign w_eq     = read_data1 == read_data2;

  always_comb begin
    w_a_lt_b = 1'b0;
    if (w_a_sign != w_b_sign) begin
      w_a_lt_b = w_a_sign;
    end else if (w_a_sign) begin
      w_a_lt_b = !w_mag_lt && !w_mag_eq;
    end else begin
      w_a_lt_b = w_mag_lt;
    end
  end

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance && !rst;

  always_comb begin
    w_canon_nan              = '0;
    w_canon_nan[W-2 -: EXP_W] = '1;
    w_canon_nan[MAN_W-1]     = 1'b1;
  end

  // Ties (bit-identical operands) fall through to operand A in both directions.
  always_comb begin
    w_sel = r_s1_a;
    if (r_s1_a_nan && r_s1_b_nan) begin
      w_sel = w_canon_nan;
    end else if (r_s1_a_nan) begin
      w_sel = r_s1_b;
    end else if (r_s1_b_nan) begin
      w_sel = r_s1_a;
    end else if (r_s1_op_max) begin
      w_sel = r_s1_a_lt_b ? r_s1_b : r_s1_a;
    end else begin
      w_sel = (!r_s1_a_lt_b && !r_s1_eq) ? r_s1_b : r_s1_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op_max <= 1'b0;
      r_s1_a_nan  <= 1'b0;
      r_s1_b_nan  <= 1'b0;
      r_s1_nv     <= 1'b0;
      r_s1_a_lt_b <= 1'b0;
      r_s1_eq     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_nv        <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a      <= read_data1;
        r_s1_b      <= read_data2;
        r_s1_op_max <= op_max;
        r_s1_a_nan  <= w_a_nan;
        r_s1_b_nan  <= w_b_nan;
        r_s1_nv     <= w_a_snan || w_b_snan;
        r_s1_a_lt_b <= w_a_lt_b;
        r_s1_eq     <= w_eq;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_sel;
        r_nv     <= r_s1_nv;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign result_out = r_result;
  assign nv_flag    = r_nv;

endmodule
